// File: rtl/buffer_pkg.sv
// Shared defaults for the buffer read controller: word width, address width,
// push/pop widths and the occupancy-counter width helper.
package buffer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_PAR_WRITE  = 2;
  localparam int DEF_PAR_READ   = 1;

  // Occupancy needs one extra bit so a completely full buffer (count = D) fits.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/ptr_wrap_counter.sv
// Buffer pointer: advances by a fixed step and wraps by natural truncation
// to WIDTH bits. Synchronous reset and synchronous clear both return it to 0.
module ptr_wrap_counter #(
  parameter int WIDTH = 3,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_reg;

  // Pointer register: reset/clear to 0, otherwise step when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_reg <= '0;
    end else if (en) begin
      value_reg <= value_reg + WIDTH'(STEP);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/buffer_read_ctrl.sv
// Read-side controller for a circular word buffer. The writer commits
// PAR_WRITE words per push at waddr; this block tracks occupancy, steps the
// read pointer and registers PAR_READ words per beat onto a valid/ready
// output. Optional sticky overflow flag: define BUFFER_READ_CTRL_OVF_EN.
module buffer_read_ctrl
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PAR_WRITE  = DEF_PAR_WRITE,
  parameter int PAR_READ   = DEF_PAR_READ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wen,
  output logic [ADDR_WIDTH-1:0]          waddr,
  output logic                           full,
  output logic [ADDR_WIDTH-1:0]          raddr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] buf_dout,
  output logic [PAR_READ*DATA_WIDTH-1:0] dout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           empty,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           ovf
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH = cnt_width(ADDR_WIDTH);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] PW_C    = CNT_WIDTH'(PAR_WRITE);
  localparam logic [CNT_WIDTH-1:0] PR_C    = CNT_WIDTH'(PAR_READ);

  // A push or beat wider than the whole buffer can never be satisfied.
  if (PAR_WRITE > DEPTH || PAR_READ > DEPTH || PAR_WRITE < 1 || PAR_READ < 1) begin : g_param_check
    $error("buffer_read_ctrl: PAR_WRITE and PAR_READ must be in 1..2**ADDR_WIDTH");
  end

  logic [CNT_WIDTH-1:0]           count_reg;
  logic [CNT_WIDTH-1:0]           count_next;
  logic                           out_valid_reg;
  logic [PAR_READ*DATA_WIDTH-1:0] dout_reg;
  logic                           push;
  logic                           load;

  // Flags come from the registered count only, so wen/out_ready never
  // reach full/empty combinationally.
  assign full  = (DEPTH_C - count_reg) < PW_C;
  assign empty = count_reg < PR_C;

  // A push is accepted only when there is room; a load happens whenever a
  // full beat is stored and the output register is free or being drained.
  assign push = wen && !full;
  assign load = (count_reg >= PR_C) && (!out_valid_reg || out_ready);

  // Occupancy after this cycle's accepted push and/or load.
  always_comb begin
    count_next = count_reg;
    if (push) begin
      count_next = count_next + PW_C;
    end
    if (load) begin
      count_next = count_next - PR_C;
    end
  end

  // Occupancy register: reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Output valid: set on a load, dropped once the consumer takes the beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_reg <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Output data lanes: capture the buffer words on a load, hold otherwise.
  for (genvar gi = 0; gi < PAR_READ; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_reg[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH] <= '0;
      end else if (load && !flush) begin
        dout_reg[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH] <= buf_dout[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
      end
    end
  end

  ptr_wrap_counter #(
    .WIDTH (ADDR_WIDTH),
    .STEP  (PAR_WRITE)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .en    (push),
    .value (waddr)
  );

  ptr_wrap_counter #(
    .WIDTH (ADDR_WIDTH),
    .STEP  (PAR_READ)
  ) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .en    (load),
    .value (raddr)
  );

`ifdef BUFFER_READ_CTRL_OVF_EN
  logic ovf_reg;

  // Sticky overflow: a push attempted while full; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (wen && full && !flush) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign dout      = dout_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Directed bench for buffer_read_ctrl at default parameters (D = 8,
// PAR_WRITE = 2, PAR_READ = 1) with a small behavioural word buffer.
module tb_buffer_read_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          full;
  logic [AW-1:0] raddr;
  logic [DW-1:0] buf_dout;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;

  logic [DW-1:0] wa;
  logic [DW-1:0] wb;
  logic [DW-1:0] mem [0:7];
  logic [AW-1:0] waddr_p1;

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_ovf;

  always #5 clk = ~clk;

  buffer_read_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wen       (wen),
    .waddr     (waddr),
    .full      (full),
    .raddr     (raddr),
    .buf_dout  (buf_dout),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf)
  );

  // Behavioural buffer: writer stores two words per accepted push.
  assign waddr_p1 = waddr + 3'd1;
  assign buf_dout = mem[raddr];

  always @(posedge clk) begin
    if (wen && !full && !rst && !flush) begin
      mem[waddr]    <= wa;
      mem[waddr_p1] <= wb;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end else begin
      $display("ok   %s: %0h", tag, actual);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " waddr"}, 32'(waddr), 32'd0);
    check({tag, " raddr"}, 32'(raddr), 32'd0);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " dout"}, 32'(dout), 32'd0);
    check({tag, " full"}, 32'(full), 32'd0);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " ovf"}, 32'(ovf), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] got [0:15];
    int beats;
    logic prev7;
    logic wrapped;

`ifdef BUFFER_READ_CTRL_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rst = 1'b0; flush = 1'b0; wen = 1'b0; out_ready = 1'b0; wa = '0; wb = '0;

    // Reset state
    do_reset();
    check_reset_state("reset");

    // Single push, consumer always ready
    out_ready = 1'b1;
    wen = 1'b1; wa = 16'h1111; wb = 16'h2222;
    step();
    wen = 1'b0;
    check("push1 count", 32'(count), 32'd2);
    check("push1 valid", 32'(out_valid), 32'd0);
    check("push1 waddr", 32'(waddr), 32'd2);
    step();
    check("push1 beatA valid", 32'(out_valid), 32'd1);
    check("push1 beatA dout", 32'(dout), 32'h1111);
    step();
    check("push1 beatB dout", 32'(dout), 32'h2222);
    check("push1 count0", 32'(count), 32'd0);
    check("push1 empty", 32'(empty), 32'd1);
    step();
    check("push1 drained", 32'(out_valid), 32'd0);

    // Fill with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wen = 1'b1; wa = 16'hA000 + 16'(2*p); wb = 16'hA000 + 16'(2*p + 1);
      step();
    end
    check("fill count", 32'(count), 32'd7);
    check("fill full", 32'(full), 32'd1);
    check("fill waddr", 32'(waddr), 32'd0);
    check("fill dout", 32'(dout), 32'hA000);
    wa = 16'hDEAD; wb = 16'hBEEF;
    step();
    wen = 1'b0;
    check("fill5 waddr", 32'(waddr), 32'd0);
    check("fill5 count", 32'(count), 32'd7);
    step();
    check("ovf sticky", 32'(ovf), 32'(exp_ovf));

    // Drain: words must emerge in push order, raddr wraps back to 0
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("drain beat%0d", k), 32'(dout), 32'hA000 + 32'(k));
    end
    step();
    check("drain valid", 32'(out_valid), 32'd0);
    check("drain empty", 32'(empty), 32'd1);
    check("drain raddr", 32'(raddr), 32'd0);
    check("ovf held", 32'(ovf), 32'(exp_ovf));

    // Wrap: 6 pushes every other cycle, continuous ready
    beats = 0; prev7 = 1'b0; wrapped = 1'b0;
    for (int c = 0; c < 16; c++) begin
      wen = (c < 12) && (c % 2 == 0);
      wa = 16'hB000 + 16'(c);
      wb = 16'hB000 + 16'(c + 1);
      step();
      if (out_valid && beats < 16) begin
        got[beats] = dout;
        beats++;
      end
      if (prev7 && raddr == 3'd0) wrapped = 1'b1;
      prev7 = (raddr == 3'd7);
    end
    wen = 1'b0;
    check("wrap beats", 32'(beats), 32'd12);
    check("wrap raddr 7->0", 32'(wrapped), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (i < beats) check($sformatf("wrap word%0d", i), 32'(got[i]), 32'hB000 + 32'(i));
    end

    // Backpressure: ready 1,0,0,1 after two pushes
    do_reset();
    check("bp ovf cleared", 32'(ovf), 32'd0);
    out_ready = 1'b0;
    wen = 1'b1; wa = 16'hC000; wb = 16'hC001;
    step();
    wa = 16'hC002; wb = 16'hC003;
    step();
    wen = 1'b0;
    check("bp first", 32'(dout), 32'hC000);
    check("bp count", 32'(count), 32'd3);
    out_ready = 1'b1; step();
    check("bp r1", 32'(dout), 32'hC001);
    out_ready = 1'b0; step();
    check("bp hold1", 32'(dout), 32'hC001);
    check("bp hold1 valid", 32'(out_valid), 32'd1);
    step();
    check("bp hold2", 32'(dout), 32'hC001);
    out_ready = 1'b1; step();
    check("bp r2", 32'(dout), 32'hC002);
    step();
    check("bp r3", 32'(dout), 32'hC003);
    step();
    check("bp done", 32'(out_valid), 32'd0);

    // Flush with count = 3 and wen high
    do_reset();
    out_ready = 1'b0;
    wen = 1'b1; wa = 16'hD000; wb = 16'hD001;
    step();
    step();
    check("flush pre count", 32'(count), 32'd3);
    flush = 1'b1; wen = 1'b1;
    step();
    flush = 1'b0; wen = 1'b0;
    check("flush count", 32'(count), 32'd0);
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush waddr", 32'(waddr), 32'd0);
    check("flush raddr", 32'(raddr), 32'd0);

    // Reset mid-beat with every other input active
    out_ready = 1'b1;
    wen = 1'b1; wa = 16'hE000; wb = 16'hE001;
    step();
    step();
    check("mid valid", 32'(out_valid), 32'd1);
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; wen = 1'b0;
    check_reset_state("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
